// File: rtl/ascii_motor_cmd_parser.sv
// ascii_motor_cmd_parser
// Turns a UART byte stream of text lines "<CMD>[sign]<digits><LF>" into
// decoded motor commands. S/s = speed, P/p = position (signed decimal
// argument), X/x = stop (no argument). CR is ignored, LF ends a line.
// A malformed line raises a one-cycle err_pulse, and the rest of the line
// up to the next LF is thrown away.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid      byte stream from UART RX
//   in_ready              low only while a decoded command waits for pickup
//   cmd_valid/cmd_ready   command handshake towards the motor core
//   cmd_type              0=STOP, 1=SPEED, 2=POS
//   cmd_value             signed argument (0 for STOP)
//   err_pulse             one-cycle syntax-error strobe
//   err_code              1=bad char, 2=too many digits, 3=range overflow (sticky)
module ascii_motor_cmd_parser #(
  parameter int VALUE_W    = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_type,
  output logic [VALUE_W-1:0] cmd_value,
  output logic               err_pulse,
  output logic [1:0]         err_code
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SIGN    = 3'd1,
    DIGITS  = 3'd2,
    XEND    = 3'd3,
    DISCARD = 3'd4,
    EMIT    = 3'd5
  } state_t;

  // Accumulator holds any MAX_DIGITS-digit number; EW adds headroom so the
  // *10 + digit step never wraps before the overflow comparison.
  localparam int AW = $clog2(10 ** MAX_DIGITS);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int EW = AW + 4;

  localparam logic [EW-1:0] POS_LIM = EW'((64'd1 << (VALUE_W - 1)) - 64'd1);
  localparam logic [EW-1:0] NEG_LIM = EW'(64'd1 << (VALUE_W - 1));
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] T_STOP  = 2'd0;
  localparam logic [1:0] T_SPEED = 2'd1;
  localparam logic [1:0] T_POS   = 2'd2;

  state_t            state_r;
  logic [1:0]        type_r;
  logic [AW-1:0]     acc_r;
  logic              neg_r;
  logic [CW-1:0]     cnt_r;
  logic              ovf_r;

  logic              xfer_s;
  logic              is_lf_s;
  logic              is_cr_s;
  logic              is_digit_s;
  logic              is_s_s;
  logic              is_p_s;
  logic              is_x_s;
  logic [EW-1:0]     acc_ext_s;
  logic [EW-1:0]     acc_next_s;
  logic              ovf_next_s;
  logic [VALUE_W-1:0] acc_trunc_s;
  logic [VALUE_W-1:0] value_s;

  // Byte classification, next accumulator value and signed result.
  always_comb begin
    xfer_s     = in_valid && in_ready;
    is_lf_s    = (in_data == 8'h0A);
    is_cr_s    = (in_data == 8'h0D);
    is_digit_s = (in_data >= 8'h30) && (in_data <= 8'h39);
    is_s_s     = (in_data == 8'h53) || (in_data == 8'h73);
    is_p_s     = (in_data == 8'h50) || (in_data == 8'h70);
    is_x_s     = (in_data == 8'h58) || (in_data == 8'h78);
    acc_ext_s  = {4'd0, acc_r};
    // For '0'..'9' the low nibble of the ASCII code is the digit value.
    acc_next_s = (acc_ext_s << 3) + (acc_ext_s << 1) + {{(EW-4){1'b0}}, in_data[3:0]};
    // A negative argument may reach one more than the positive limit.
    if (neg_r) begin
      ovf_next_s = (acc_next_s > NEG_LIM);
    end else begin
      ovf_next_s = (acc_next_s > POS_LIM);
    end
    acc_trunc_s = VALUE_W'(acc_r);
    if (neg_r) begin
      value_s = -acc_trunc_s;
    end else begin
      value_s = acc_trunc_s;
    end
  end

  // Line parser FSM with registered handshake, command and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      type_r    <= T_STOP;
      acc_r     <= {AW{1'b0}};
      neg_r     <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      ovf_r     <= 1'b0;
      in_ready  <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_type  <= T_STOP;
      cmd_value <= {VALUE_W{1'b0}};
      err_pulse <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      err_pulse <= 1'b0;
      if (state_r == EMIT) begin
        // cmd_valid is always high here, so cmd_ready alone completes it.
        if (cmd_ready) begin
          cmd_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      end else if (xfer_s && !is_cr_s) begin
        case (state_r)
          IDLE: begin
            if (is_s_s || is_p_s) begin
              type_r  <= is_s_s ? T_SPEED : T_POS;
              acc_r   <= {AW{1'b0}};
              neg_r   <= 1'b0;
              cnt_r   <= {CW{1'b0}};
              ovf_r   <= 1'b0;
              state_r <= SIGN;
            end else if (is_x_s) begin
              type_r  <= T_STOP;
              state_r <= XEND;
            end else if (!is_lf_s) begin
              err_pulse <= 1'b1;
              err_code  <= 2'd1;
              state_r   <= DISCARD;
            end
          end
          XEND: begin
            if (is_lf_s) begin
              cmd_valid <= 1'b1;
              in_ready  <= 1'b0;
              cmd_type  <= type_r;
              cmd_value <= {VALUE_W{1'b0}};
              state_r   <= EMIT;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= 2'd1;
              state_r   <= DISCARD;
            end
          end
          SIGN: begin
            if (in_data == 8'h2D) begin
              neg_r   <= 1'b1;
              state_r <= DIGITS;
            end else if (in_data == 8'h2B) begin
              state_r <= DIGITS;
            end else if (is_digit_s) begin
              acc_r   <= acc_next_s[AW-1:0];
              cnt_r   <= CNT_ONE;
              ovf_r   <= ovf_next_s;
              state_r <= DIGITS;
            end else if (is_lf_s) begin
              err_pulse <= 1'b1;
              err_code  <= 2'd1;
              state_r   <= IDLE;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= 2'd1;
              state_r   <= DISCARD;
            end
          end
          DIGITS: begin
            if (is_digit_s) begin
              if (cnt_r >= CNT_MAX) begin
                err_pulse <= 1'b1;
                err_code  <= 2'd2;
                state_r   <= DISCARD;
              end else begin
                acc_r <= acc_next_s[AW-1:0];
                cnt_r <= cnt_r + CNT_ONE;
                ovf_r <= ovf_r | ovf_next_s;
              end
            end else if (is_lf_s) begin
              if (cnt_r == {CW{1'b0}}) begin
                err_pulse <= 1'b1;
                err_code  <= 2'd1;
                state_r   <= IDLE;
              end else if (ovf_r) begin
                err_pulse <= 1'b1;
                err_code  <= 2'd3;
                state_r   <= IDLE;
              end else begin
                cmd_valid <= 1'b1;
                in_ready  <= 1'b0;
                cmd_type  <= type_r;
                cmd_value <= value_s;
                state_r   <= EMIT;
              end
            end else begin
              err_pulse <= 1'b1;
              err_code  <= 2'd1;
              state_r   <= DISCARD;
            end
          end
          DISCARD: begin
            if (is_lf_s) begin
              state_r <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascii_motor_cmd_parser.sv
module tb_ascii_motor_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [15:0] cmd_value;
  logic        err_pulse;
  logic [1:0]  err_code;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Scoreboard: expected commands {type, value} and expected error codes.
  logic [17:0] exp_cmd_q[$];
  logic [1:0]  exp_err_q[$];
  logic [17:0] exp_cmd;
  logic [1:0]  exp_err;

  ascii_motor_cmd_parser #(.VALUE_W(16), .MAX_DIGITS(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_value (cmd_value),
    .err_pulse (err_pulse),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every handshake and every error pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      compared++;
      if (exp_cmd_q.size() == 0) begin
        mismatched++;
        $display("FAIL cmd_unexpected: got type=%0d value=%h, required no command", cmd_type, cmd_value);
      end else begin
        exp_cmd = exp_cmd_q.pop_front();
        if ({cmd_type, cmd_value} !== exp_cmd) begin
          mismatched++;
          $display("FAIL cmd_content: got type=%0d value=%h, required type=%0d value=%h",
                   cmd_type, cmd_value, exp_cmd[17:16], exp_cmd[15:0]);
        end
      end
    end
    if (rst_n === 1'b1 && err_pulse === 1'b1) begin
      compared++;
      if (exp_err_q.size() == 0) begin
        mismatched++;
        $display("FAIL err_unexpected: got err_code=%0d, required no error", err_code);
      end else begin
        exp_err = exp_err_q.pop_front();
        if (err_code !== exp_err) begin
          mismatched++;
          $display("FAIL err_code: got %0d, required %0d", err_code, exp_err);
        end
      end
    end
  end

  // Offer one byte and return 1 ns after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({in_ready, cmd_valid, cmd_type, cmd_value, err_pulse, err_code} !==
        {1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0}) begin
      mismatched++;
      $display("FAIL reset_values: got rdy=%b vld=%b type=%0d val=%h ep=%b ec=%0d, required 1 0 0 0000 0 0",
               in_ready, cmd_valid, cmd_type, cmd_value, err_pulse, err_code);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_speed();
    exp_cmd_q.push_back({2'd1, 16'd1234});
    send_line("S1234\n");
    compared++;
    if (cmd_valid !== 1'b1 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL speed_latency: got vld=%b rdy=%b, required vld=1 rdy=0", cmd_valid, in_ready);
    end
    @(posedge clk);
    #1;
    compared++;
    if (cmd_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL speed_release: got vld=%b rdy=%b, required vld=0 rdy=1", cmd_valid, in_ready);
    end
  endtask

  task automatic test_boundaries();
    exp_cmd_q.push_back({2'd2, 16'h8000});
    send_line("p-32768");
    send_byte(8'h0D);
    send_byte(8'h0A);
    exp_err_q.push_back(2'd3);
    send_line("S32768\n");
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (err_code !== 2'd3 || err_pulse !== 1'b0) begin
      mismatched++;
      $display("FAIL err_hold: got ec=%0d ep=%b, required ec=3 ep=0", err_code, err_pulse);
    end
  endtask

  task automatic test_backpressure();
    exp_cmd_q.push_back({2'd1, 16'h8000});
    exp_cmd_q.push_back({2'd0, 16'h0000});
    cmd_ready = 1'b0;
    send_line("S-32768\n");
    // Next line's first byte is offered during the stall and must be held off.
    in_data  = 8'h78;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if ({cmd_valid, in_ready, cmd_type, cmd_value} !== {1'b1, 1'b0, 2'd1, 16'h8000}) begin
        mismatched++;
        $display("FAIL stall_%0d: got vld=%b rdy=%b type=%0d val=%h, required 1 0 1 8000",
                 i, cmd_valid, in_ready, cmd_type, cmd_value);
      end
      @(posedge clk);
      #1;
    end
    cmd_ready = 1'b1;
    send_line("x\n");
  endtask

  task automatic test_stop_and_limit();
    exp_err_q.push_back(2'd1);
    send_line("X5\n");
    exp_err_q.push_back(2'd2);
    send_line("S12345");
    send_byte(8'h36);
    compared++;
    if (err_pulse !== 1'b1 || err_code !== 2'd2) begin
      mismatched++;
      $display("FAIL digit_limit: got ep=%b ec=%0d, required ep=1 ec=2", err_pulse, err_code);
    end
    @(posedge clk);
    #1;
    compared++;
    if (err_pulse !== 1'b0) begin
      mismatched++;
      $display("FAIL err_one_cycle: got ep=%b, required 0", err_pulse);
    end
    send_line("7\n");
  endtask

  task automatic test_resync();
    exp_err_q.push_back(2'd1);
    exp_cmd_q.push_back({2'd1, 16'd7});
    send_line("S12a34\nS+7\n\n\n");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int c0;
    exp_cmd_q.push_back({2'd1, 16'd1});
    exp_cmd_q.push_back({2'd2, 16'd2});
    c0 = cyc;
    send_line("S1\nP2\n");
    compared++;
    if (cyc - c0 !== 7) begin
      mismatched++;
      $display("FAIL back_to_back: took %0d cycles, required 7", cyc - c0);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    send_line("S12");
    rst_n = 1'b0;
    #1;
    compared++;
    if ({in_ready, cmd_valid, cmd_type, cmd_value, err_pulse, err_code} !==
        {1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0}) begin
      mismatched++;
      $display("FAIL mid_reset: got rdy=%b vld=%b type=%0d val=%h ep=%b ec=%0d, required 1 0 0 0000 0 0",
               in_ready, cmd_valid, cmd_type, cmd_value, err_pulse, err_code);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cmd_q.push_back({2'd1, 16'd9});
    send_line("S9\n");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    cmd_ready = 1'b1;
    test_reset();
    test_speed();
    test_boundaries();
    test_backpressure();
    test_stop_and_limit();
    test_resync();
    test_back_to_back();
    test_reset_mid();
    compared++;
    if (exp_cmd_q.size() != 0 || exp_err_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d commands and %0d errors outstanding, required 0 and 0",
               exp_cmd_q.size(), exp_err_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
